// File: rtl/uc_secuenciador.sv
// uc_secuenciador: control unit for the single-cycle microcontroller.
// Combinational Mealy decode of Opcode/z plus a RUN/HALTED state machine
// for HALT and run-resume, a saturating retired-instruction counter and a
// sticky illegal-opcode flag.
module uc_secuenciador #(
    parameter int unsigned CW       = 16,
    parameter int unsigned ILL_HALT = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [5:0]    Opcode,
    input  logic          z,
    input  logic          run,
    output logic          s_inc,
    output logic          s_inm,
    output logic          we3,
    output logic          wez,
    output logic [2:0]    Op,
    output logic          halted,
    output logic          illegal,
    output logic [CW-1:0] icount
);

    localparam logic [5:0]    OPC_J       = 6'b010000;
    localparam logic [5:0]    OPC_JZ      = 6'b010001;
    localparam logic [5:0]    OPC_JNZ     = 6'b010010;
    localparam logic [5:0]    OPC_HALT    = 6'b011111;
    localparam logic [CW-1:0] ICOUNT_MAX  = {CW{1'b1}};
    localparam bit            ILL_AS_HALT = (ILL_HALT != 0);

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t state;
    state_t state_next;

    logic is_alu;
    logic is_li;
    logic is_j;
    logic is_jz;
    logic is_jnz;
    logic is_halt;
    logic is_illegal;
    logic halt_like;

    // Instruction class flags; the low opcode bits of ALU/LI belong to operand fields
    always_comb begin
        is_alu     = Opcode[5];
        is_li      = (Opcode[5:2] == 4'b0000);
        is_j       = (Opcode == OPC_J);
        is_jz      = (Opcode == OPC_JZ);
        is_jnz     = (Opcode == OPC_JNZ);
        is_halt    = (Opcode == OPC_HALT);
        is_illegal = ~(is_alu | is_li | is_j | is_jz | is_jnz | is_halt);
        halt_like  = is_halt | (ILL_AS_HALT & is_illegal);
    end

    // Control decode and next state; outputs are same-cycle for the datapath
    always_comb begin
        s_inc      = 1'b1;
        s_inm      = 1'b0;
        we3        = 1'b0;
        wez        = 1'b0;
        Op         = 3'b000;
        state_next = state;
        unique case (state)
            ST_RUN: begin
                if (is_alu) begin
                    Op  = Opcode[4:2];
                    we3 = 1'b1;
                    wez = 1'b1;
                end else if (is_li) begin
                    s_inm = 1'b1;
                    we3   = 1'b1;
                end else if (is_j) begin
                    s_inc = 1'b0;
                end else if (is_jz) begin
                    s_inc = ~z;
                end else if (is_jnz) begin
                    s_inc = z;
                end else if (halt_like) begin
                    s_inc = 1'b0;
                end
                if (halt_like) begin
                    state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                // HALT jumps to itself; advancing past it resumes, as does a PC
                // that no longer points at a HALT
                if (run || !halt_like) begin
                    state_next = ST_RUN;
                end else begin
                    s_inc = 1'b0;
                end
            end
        endcase
    end

    // State, halted flag, sticky illegal flag and saturating retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_RUN;
            halted  <= 1'b0;
            illegal <= 1'b0;
            icount  <= '0;
        end else begin
            state  <= state_next;
            halted <= (state_next == ST_HALTED);
            if (state == ST_RUN) begin
                if (is_illegal) begin
                    illegal <= 1'b1;
                end
                if (icount != ICOUNT_MAX) begin
                    icount <= icount + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uc_secuenciador.sv
// Testbench for uc_secuenciador: three configurations share the stimulus,
// a small datapath closes the loop for directed programs, and a behavioural
// model predicts every output each cycle.
module tb_uc_secuenciador;

    localparam int K_ALU  = 0;
    localparam int K_LI   = 1;
    localparam int K_J    = 2;
    localparam int K_JZ   = 3;
    localparam int K_JNZ  = 4;
    localparam int K_HALT = 5;
    localparam int K_ILL  = 6;
    localparam logic [2:0] OP_SUB = 3'd3;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       z;
    logic       run;

    logic [2:0]  o_sinc, o_sinm, o_we3, o_wez, o_halted, o_illegal;
    logic [2:0]  o_op [3];
    logic [15:0] ic0, ic1;
    logic [3:0]  ic2;

    int checks = 0;
    int failures = 0;

    bit ih_cfg [3]  = '{1'b0, 1'b1, 1'b0};
    int sat_cfg [3] = '{65535, 65535, 15};
    bit m_halted [3];
    bit m_illegal [3];
    int m_icount [3];

    // datapath model
    logic [15:0] imem [0:1023];
    logic [7:0]  rf [16];
    logic [9:0]  pc;
    logic        zreg;
    bit          dp_en;
    logic        c_sinc, c_sinm, c_we3, c_wez;
    logic [2:0]  c_op;

    uc_secuenciador #(.CW(16), .ILL_HALT(0)) u0 (
        .clk(clk), .reset(reset), .Opcode(opcode), .z(z), .run(run),
        .s_inc(o_sinc[0]), .s_inm(o_sinm[0]), .we3(o_we3[0]), .wez(o_wez[0]),
        .Op(o_op[0]), .halted(o_halted[0]), .illegal(o_illegal[0]), .icount(ic0));

    uc_secuenciador #(.CW(16), .ILL_HALT(1)) u1 (
        .clk(clk), .reset(reset), .Opcode(opcode), .z(z), .run(run),
        .s_inc(o_sinc[1]), .s_inm(o_sinm[1]), .we3(o_we3[1]), .wez(o_wez[1]),
        .Op(o_op[1]), .halted(o_halted[1]), .illegal(o_illegal[1]), .icount(ic1));

    uc_secuenciador #(.CW(4), .ILL_HALT(0)) u2 (
        .clk(clk), .reset(reset), .Opcode(opcode), .z(z), .run(run),
        .s_inc(o_sinc[2]), .s_inm(o_sinm[2]), .we3(o_we3[2]), .wez(o_wez[2]),
        .Op(o_op[2]), .halted(o_halted[2]), .illegal(o_illegal[2]), .icount(ic2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int kind_of(input int opc);
        if (opc >= 32) return K_ALU;
        if (opc < 4) return K_LI;
        if (opc == 16) return K_J;
        if (opc == 17) return K_JZ;
        if (opc == 18) return K_JNZ;
        if (opc == 31) return K_HALT;
        return K_ILL;
    endfunction

    // expected {s_inc, s_inm, we3, wez, Op}
    function automatic logic [6:0] expect_ctrl(input bit hlt, input int opc,
                                               input bit zz, input bit rr, input bit ih);
        int  k;
        bit  hl;
        logic [2:0] alu_op;
        k = kind_of(opc);
        hl = (k == K_HALT) || (k == K_ILL && ih);
        alu_op = 3'((opc / 4) % 8);
        if (hlt) return {(rr || !hl), 6'b000000};
        case (k)
            K_ALU:   return {4'b1011, alu_op};
            K_LI:    return 7'b1110000;
            K_J:     return 7'b0000000;
            K_JZ:    return {!zz, 6'b000000};
            K_JNZ:   return {zz, 6'b000000};
            K_HALT:  return 7'b0000000;
            default: return {!ih, 6'b000000};
        endcase
    endfunction

    function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd2:    return a + b;
            3'd3:    return a - b;
            3'd4:    return a & b;
            3'd5:    return a | b;
            default: return a;
        endcase
    endfunction

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            logic [6:0] e;
            logic [31:0] icv;
            e = expect_ctrl(m_halted[i], int'(opcode), z, run, ih_cfg[i]);
            icv = (i == 0) ? 32'(ic0) : (i == 1) ? 32'(ic1) : 32'(ic2);
            chk("s_inc",   i, 32'(o_sinc[i]),    32'(e[6]));
            chk("s_inm",   i, 32'(o_sinm[i]),    32'(e[5]));
            chk("we3",     i, 32'(o_we3[i]),     32'(e[4]));
            chk("wez",     i, 32'(o_wez[i]),     32'(e[3]));
            chk("op",      i, 32'(o_op[i]),      32'(e[2:0]));
            chk("halted",  i, 32'(o_halted[i]),  32'(m_halted[i]));
            chk("illegal", i, 32'(o_illegal[i]), 32'(m_illegal[i]));
            chk("icount",  i, icv,               32'(m_icount[i]));
        end
    endtask

    task automatic update_models();
        for (int i = 0; i < 3; i++) begin
            int k;
            bit hl;
            k = kind_of(int'(opcode));
            hl = (k == K_HALT) || (k == K_ILL && ih_cfg[i]);
            if (reset) begin
                m_halted[i]  = 1'b0;
                m_illegal[i] = 1'b0;
                m_icount[i]  = 0;
            end else if (!m_halted[i]) begin
                if (m_icount[i] < sat_cfg[i]) m_icount[i]++;
                if (k == K_ILL) m_illegal[i] = 1'b1;
                if (hl) m_halted[i] = 1'b1;
            end else if (run || !hl) begin
                m_halted[i] = 1'b0;
            end
        end
    endtask

    task automatic update_datapath();
        logic [15:0] ins;
        logic [7:0]  res;
        if (reset) begin
            pc   = '0;
            zreg = 1'b0;
        end else begin
            ins = imem[pc];
            res = alu(c_op, rf[ins[11:8]], rf[ins[7:4]]);
            if (c_we3) rf[ins[3:0]] = c_sinm ? ins[11:4] : res;
            if (c_wez) zreg = (res == 8'd0);
            pc = c_sinc ? pc + 10'd1 : ins[9:0];
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        c_sinc = o_sinc[0];
        c_sinm = o_sinm[0];
        c_we3  = o_we3[0];
        c_wez  = o_wez[0];
        c_op   = o_op[0];
        @(posedge clk);
        update_models();
        update_datapath();
        #1;
        if (dp_en) begin
            opcode = imem[pc][15:10];
            z      = zreg;
        end
        #1;
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) imem[a] = 16'h0000;
        for (int r = 0; r < 16; r++) rf[r] = 8'h00;
        imem[10'h000] = {4'b0000, 8'd5, 4'd1};               // LI 5,R1
        imem[10'h001] = {4'b0000, 8'd3, 4'd2};               // LI 3,R2
        imem[10'h002] = {1'b1, OP_SUB, 4'd1, 4'd2, 4'd3};    // R3 = R1-R2
        imem[10'h003] = {6'b010001, 10'h020};                // JZ 0x020
        imem[10'h004] = {1'b1, OP_SUB, 4'd1, 4'd1, 4'd4};    // R4 = R1-R1
        imem[10'h005] = {6'b010001, 10'h020};                // JZ 0x020
        imem[10'h020] = {6'b010000, 10'h00A};                // J 0x00A
        imem[10'h00A] = {6'b011111, 10'h00A};                // HALT
        imem[10'h00B] = {6'b011000, 10'h000};                // illegal
        imem[10'h00C] = {6'b010000, 10'h00A};                // J 0x00A

        dp_en = 1'b1;
        pc = '0;
        zreg = 1'b0;
        reset = 1'b1;
        run = 1'b0;
        opcode = imem[0][15:10];
        z = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_halted[i] = 1'b0;
            m_illegal[i] = 1'b0;
            m_icount[i] = 0;
        end
        #2;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_halted", 0, 32'(o_halted[0]), 32'd0);
        chk("rst_icount", 0, 32'(ic0), 32'd0);
        chk("rst_pc", 0, 32'(pc), 32'd0);

        // LI, LI, SUB
        tick();
        tick();
        chk("sub_op", 0, 32'(o_op[0]), 32'(OP_SUB));
        chk("sub_we3", 0, 32'(o_we3[0]), 32'd1);
        chk("sub_wez", 0, 32'(o_wez[0]), 32'd1);
        chk("sub_sinc", 0, 32'(o_sinc[0]), 32'd1);
        tick();
        chk("icount3", 0, 32'(ic0), 32'd3);
        chk("jz_nt_sinc", 0, 32'(o_sinc[0]), 32'd1);
        tick();
        chk("jz_nt_pc", 0, 32'(pc), 32'h004);
        tick();
        chk("jz_t_z", 0, 32'(z), 32'd1);
        chk("jz_t_sinc", 0, 32'(o_sinc[0]), 32'd0);
        tick();
        chk("jz_t_pc", 0, 32'(pc), 32'h020);
        tick();
        chk("halt_pc", 0, 32'(pc), 32'h00A);
        chk("halt_sinc", 0, 32'(o_sinc[0]), 32'd0);
        chk("halt_pre", 0, 32'(o_halted[0]), 32'd0);
        tick();
        chk("halted", 0, 32'(o_halted[0]), 32'd1);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("hold_pc", c, 32'(pc), 32'h00A);
            chk("hold_we3", c, 32'(o_we3[0]), 32'd0);
            chk("hold_wez", c, 32'(o_wez[0]), 32'd0);
            chk("hold_icount", c, 32'(ic0), 32'd8);
        end

        // resume, run held high into RUN over an illegal opcode
        run = 1'b1;
        #1;
        chk("resume_sinc", 0, 32'(o_sinc[0]), 32'd1);
        tick();
        chk("resume_pc", 0, 32'(pc), 32'h00B);
        chk("resume_halted", 0, 32'(o_halted[0]), 32'd0);
        chk("ill_sinc", 0, 32'(o_sinc[0]), 32'd1);
        chk("ill_we3", 0, 32'(o_we3[0]), 32'd0);
        tick();
        chk("ill_pc", 0, 32'(pc), 32'h00C);
        chk("ill_flag", 0, 32'(o_illegal[0]), 32'd1);
        chk("ill_run_halted", 0, 32'(o_halted[0]), 32'd0);
        chk("ill_halt_cfg", 1, 32'(o_halted[1]), 32'd1);
        run = 1'b0;
        tick();
        chk("rehalt_pc", 0, 32'(pc), 32'h00A);
        tick();
        chk("rehalted", 0, 32'(o_halted[0]), 32'd1);
        chk("rehalt_icount", 0, 32'(ic0), 32'd11);
        chk("ill_sticky", 0, 32'(o_illegal[0]), 32'd1);
        tick();
        tick();

        // reset while halted
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rh_halted", 0, 32'(o_halted[0]), 32'd0);
        chk("rh_icount", 0, 32'(ic0), 32'd0);
        chk("rh_illegal", 0, 32'(o_illegal[0]), 32'd0);
        chk("rh_pc", 0, 32'(pc), 32'd0);

        // saturation with the 4-bit counter
        dp_en = 1'b0;
        opcode = 6'b000000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        chk("sat_cw4", 2, 32'(ic2), 32'd15);
        chk("nosat_cw16", 0, 32'(ic0), 32'd20);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            opcode = ($urandom_range(0, 3) == 0) ? 6'b011111 : 6'($urandom_range(0, 63));
            z      = 1'($urandom_range(0, 1));
            run    = ($urandom_range(0, 3) == 0);
            reset  = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
